// File: rtl/product_acc_pkg.sv
// Shared types, default widths and helpers for the product accumulator.
// Build option: SATURATE_EN selects clamping instead of wrap-around on overflow.
package product_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int CNT_W_DEF  = 8;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    // Works for any w in 1..64, including w equal to the destination width.
    function automatic logic [63:0] sext_prod(input logic [63:0] p, input int unsigned w);
        logic signed [63:0] s;
        s = $signed(p << (64 - w));
        return s >>> (64 - w);
    endfunction

endpackage

// File: rtl/acc_add_sat.sv
// Signed W-bit adder with overflow flag; clamps to the signed range when SATURATE_EN is defined.
module acc_add_sat
    import product_acc_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    assign raw = a + b;
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef SATURATE_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    // Both operands share a sign on overflow, so a's sign picks the rail.
    assign sum = ovf ? (a[W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Accumulates a stream of signed products into one result per in_last-terminated group.
// Build option: SATURATE_EN (see acc_add_sat) clamps the running sum on overflow.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               beat;
    logic               first;
    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   prod_ext;
    logic [ACC_W-1:0]   add_sum;
    logic               add_ovf;
    logic [CNT_W-1:0]   count_inc;

    assign in_ready  = (state_q != DONE);
    assign beat      = in_valid && in_ready;
    assign first     = (state_q == IDLE);
    // The first beat loads rather than adds, so feed zero instead of the stale sum.
    assign add_a     = first ? '0 : acc_q;
    assign prod_ext  = ACC_W'(sext_prod(64'(in_prod), PROD_W));
    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

    acc_add_sat #(.W(ACC_W)) u_add (
        .a   (add_a),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (beat) begin
                    acc_d   = add_sum;
                    count_d = first ? CNT_W'(1) : count_inc;
                    ovf_d   = first ? add_ovf : (ovf_q | add_ovf);
                    if (in_last) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_acc_d   = add_sum;
                        out_count_d = count_d;
                        out_ovf_d   = ovf_d;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: a 24-bit accumulator for the main stream and a 16-bit one for overflow cases.
module tb_product_accumulator;

    typedef struct {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [15:0] in_prod = '0;
    logic        in_ready, out_valid, out_ovf;
    logic [23:0] out_acc;
    logic [7:0]  out_count;

    logic        in_valid1 = 1'b0, in_last1 = 1'b0, out_ready1 = 1'b1;
    logic [15:0] in_prod1 = '0;
    logic        in_ready1, out_valid1, out_ovf1;
    logic [15:0] out_acc1;
    logic [7:0]  out_count1;

    int tests = 0;
    int fails = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    product_accumulator #(.PROD_W(16), .ACC_W(16), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_prod(in_prod1), .in_last(in_last1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .out_acc(out_acc1), .out_count(out_count1), .out_ovf(out_ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] a, input logic [7:0] c, input logic o);
        exp_t e;
        e.acc = a;
        e.cnt = c;
        e.ovf = o;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input bit which, input logic [15:0] p, input logic last);
        bit ok;
        ok = 1'b0;
        if (which) begin
            in_valid1 = 1'b1; in_prod1 = p; in_last1 = last;
        end else begin
            in_valid = 1'b1; in_prod = p; in_last = last;
        end
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = which ? in_ready1 : in_ready;
            @(posedge clk);
            #1;
        end
        if (which) in_valid1 = 1'b0;
        else       in_valid  = 1'b0;
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready, expected in_ready within 1000 cycles");
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : mon0
        bit seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dut0_unexpected: got out_acc=%h, expected no result", out_acc);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_acc", 32'(out_acc), 32'(e.acc));
                    chk("dut0_count", 32'(out_count), 32'(e.cnt));
                    chk("dut0_ovf", 32'(out_ovf), 32'(e.ovf));
                    $display("[TB] dut0 result acc=%h count=%0d ovf=%0b", out_acc, out_count, out_ovf);
                end
            end
        end
    end

    initial begin : mon1
        bit seen;
        exp_t e;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid1) begin
                seen = 1'b0;
            end else if (!seen) begin
                seen = 1'b1;
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dut1_unexpected: got out_acc=%h, expected no result", out_acc1);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_acc", 32'(out_acc1), 32'(e.acc));
                    chk("dut1_count", 32'(out_count1), 32'(e.cnt));
                    chk("dut1_ovf", 32'(out_ovf1), 32'(e.ovf));
                    $display("[TB] dut1 result acc=%h count=%0d ovf=%0b", out_acc1, out_count1, out_ovf1);
                end
            end
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", 32'(out_acc), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 1: single beat, result one cycle after acceptance
        q0.push_back(mk(24'h004000, 8'd1, 1'b0));
        send(1'b0, 16'h4000, 1'b1);
        chk("t1_latency_valid", 32'(out_valid), 32'd1);
        chk("t1_in_ready_low", 32'(in_ready), 32'd0);
        idle(2);

        // 2: 100, -300, 50 with pauses; first beat must load, not add to 0x4000
        q0.push_back(mk(24'hFFFF6A, 8'd3, 1'b0));
        send(1'b0, 16'd100, 1'b0);
        idle(2);
        send(1'b0, 16'hFED4, 1'b0);
        idle(3);
        send(1'b0, 16'd50, 1'b1);
        idle(2);

        // 3: consumer stalls for 5 cycles while a new beat waits
        out_ready = 1'b0;
        q0.push_back(mk(24'h000003, 8'd2, 1'b0));
        send(1'b0, 16'd5, 1'b0);
        send(1'b0, 16'hFFFE, 1'b1);
        in_valid = 1'b1; in_prod = 16'd9; in_last = 1'b1;
        q0.push_back(mk(24'h000009, 8'd1, 1'b0));
        repeat (5) begin
            @(negedge clk);
            chk("t3_hold_valid", 32'(out_valid), 32'd1);
            chk("t3_hold_acc", 32'(out_acc), 32'h3);
            chk("t3_hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t3_in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("t3_valid_drop", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("t3_pending_accepted", 32'(out_valid), 32'd1);
        idle(2);

        // 4: 16-bit accumulator overflow, wrap vs clamp
`ifdef SATURATE_EN
        q1.push_back(mk(24'h007FFF, 8'd2, 1'b1));
        q1.push_back(mk(24'h008000, 8'd2, 1'b1));
        q1.push_back(mk(24'h003FFF, 8'd3, 1'b1));
`else
        q1.push_back(mk(24'h008000, 8'd2, 1'b1));
        q1.push_back(mk(24'h007FFF, 8'd2, 1'b1));
        q1.push_back(mk(24'h004000, 8'd3, 1'b1));
`endif
        send(1'b1, 16'h4000, 1'b0);
        send(1'b1, 16'h4000, 1'b1);
        send(1'b1, 16'h8000, 1'b0);
        send(1'b1, 16'hFFFF, 1'b1);
        send(1'b1, 16'h4000, 1'b0);
        send(1'b1, 16'h4000, 1'b0);
        send(1'b1, 16'hC000, 1'b1);
        idle(2);

        // 5: reset mid-group discards the partial sum
        send(1'b0, 16'd10, 1'b0);
        send(1'b0, 16'd20, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_out_acc", 32'(out_acc), 32'd0);
        chk("t5_rst_out_count", 32'(out_count), 32'd0);
        chk("t5_rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(mk(24'h000007, 8'd1, 1'b0));
        send(1'b0, 16'd7, 1'b1);
        idle(2);

        // 6: 300 beats of 1, counter saturates at 255
        q0.push_back(mk(24'd300, 8'd255, 1'b0));
        for (int i = 0; i < 299; i++) send(1'b0, 16'd1, 1'b0);
        send(1'b0, 16'd1, 1'b1);
        idle(5);

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
